audio_playback_fifo: RTL and testbench

Sample buffer on the playback path, directly downstream of the RAM record/play sequencer. It captures each audio word returned by the RAM controller during play. It primes to a fill level, then releases one sample per codec sample tick. It drives `audio_rdy` back to the sequencer as flow control, so RAM reads never overrun the buffer. It also reports underrun and overflow events for the LED/debug path.

---
 rtl/audio_playback_fifo.sv | 196 +++++++++++++++++++
 tb/tb_audio_playback_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/audio_playback_fifo.sv
// Playback sample buffer between the RAM record/play sequencer and the codec.
// RAM read words are queued in a circular buffer. The buffer primes to a fill
// level and then releases one sample per codec tick. It drives audio_rdy as
// flow control back to the sequencer, and it counts underruns and flags
// overflow.
module audio_playback_fifo #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 16,
    parameter int PRIME_LEVEL  = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        ram_data,
    input  logic                     ram_valid,
    input  logic                     sample_tick,
    output logic                     audio_rdy,
    output logic [DATA_W-1:0]        sample_out,
    output logic                     sample_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               underrun_cnt,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_PRIME = CNT_W'(PRIME_LEVEL);
    // Highest fill count at which another RAM read may still be requested;
    // the remaining AFULL_MARGIN slots absorb reads already in flight.
    localparam logic [CNT_W-1:0] CNT_RDY   = CNT_W'(DEPTH - 1 - AFULL_MARGIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [7:0]          urun_q, urun_d;
    logic                ovf_q, ovf_d;
    logic                rdy_q, rdy_d;
    logic                push_s;
    logic                pop_s;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state decode: FSM, push/pop acceptance, pointer and count updates.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        sample_d = sample_q;
        valid_d  = sample_tick;
        urun_d   = urun_q;
        ovf_d    = ovf_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
                if (sample_tick) begin
                    sample_d = {DATA_W{1'b0}};
                end else begin
                    sample_d = sample_q;
                end
            end
            ST_PRIME: begin
                if (count_q >= CNT_PRIME) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PRIME;
                end
                if (sample_tick) begin
                    sample_d = {DATA_W{1'b0}};
                end else begin
                    sample_d = sample_q;
                end
            end
            ST_PLAY: begin
                if (sample_tick && (count_q != {CNT_W{1'b0}})) begin
                    pop_s    = 1'b1;
                    sample_d = mem_q[rptr_q];
                end else if (sample_tick) begin
                    // Underrun: hold the last sample and re-prime.
                    state_d = ST_PRIME;
                    if (urun_q != 8'hFF) begin
                        urun_d = urun_q + 8'd1;
                    end else begin
                        urun_d = urun_q;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pushes are taken in PRIME and PLAY; a push into a full buffer is lost.
        if ((state_q != ST_IDLE) && ram_valid) begin
            if (count_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end

        if (push_s) begin
            wptr_d = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end

        // Leaving play mode flushes the buffer but keeps sample/status outputs.
        if (!enable) begin
            state_d = ST_IDLE;
            wptr_d  = {PTR_W{1'b0}};
            rptr_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
            push_s  = 1'b0;
        end else begin
            push_s  = push_s;
        end

        // Same value as decoding the registered state/count, but held in a flop.
        rdy_d = (state_d != ST_IDLE) && (count_d <= CNT_RDY);
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wptr_q   <= {PTR_W{1'b0}};
            rptr_q   <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            sample_q <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            urun_q   <= 8'd0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            urun_q   <= urun_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
        end
    end

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= ram_data;
        end
    end

    assign audio_rdy    = rdy_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign level        = count_q;
    assign underrun_cnt = urun_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_audio_playback_fifo.sv
// Self-checking bench for audio_playback_fifo: a scoreboard queue holds the
// expected sample for every tick and a monitor pops it on each sample_valid.
module tb_audio_playback_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] ram_data;
    logic        ram_valid;
    logic        sample_tick;
    logic        audio_rdy;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [4:0]  level;
    logic [7:0]  underrun_cnt;
    logic        overflow;

    logic        s_enable;
    logic [15:0] s_ram_data;
    logic        s_ram_valid;
    logic        s_tick;
    logic        s_rdy;
    logic [15:0] s_sample_out;
    logic        s_sample_valid;
    logic [4:0]  s_level;
    logic [7:0]  s_urun;
    logic        s_ovf;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    audio_playback_fifo #(.DATA_W(16), .DEPTH(16), .PRIME_LEVEL(8), .AFULL_MARGIN(2)) dut (
        .clk(clk), .reset(rst_n), .enable(enable), .ram_data(ram_data),
        .ram_valid(ram_valid), .sample_tick(sample_tick), .audio_rdy(audio_rdy),
        .sample_out(sample_out), .sample_valid(sample_valid), .level(level),
        .underrun_cnt(underrun_cnt), .overflow(overflow)
    );

    audio_playback_fifo #(.DATA_W(16), .DEPTH(16), .PRIME_LEVEL(1), .AFULL_MARGIN(2)) u_sat (
        .clk(clk), .reset(rst_n), .enable(s_enable), .ram_data(s_ram_data),
        .ram_valid(s_ram_valid), .sample_tick(s_tick), .audio_rdy(s_rdy),
        .sample_out(s_sample_out), .sample_valid(s_sample_valid), .level(s_level),
        .underrun_cnt(s_urun), .overflow(s_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every sample_valid pulse consumes one expected sample.
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %0h expected none", sample_out);
            end else begin
                automatic logic [15:0] e = exp_q.pop_front();
                chk("sample_out", {16'h0000, sample_out}, {16'h0000, e});
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic t, input logic [15:0] e);
        if (t) exp_q.push_back(e);
        ram_valid   = v;
        ram_data    = d;
        sample_tick = t;
        @(posedge clk);
        #1;
        ram_valid   = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic sstep(input logic v, input logic [15:0] d, input logic t);
        s_ram_valid = v;
        s_ram_data  = d;
        s_tick      = t;
        @(posedge clk);
        #1;
        s_ram_valid = 1'b0;
        s_tick      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, {27'd0, level}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, audio_rdy}, 32'd0);
        chk({tag, "_sample"}, {16'd0, sample_out}, 32'd0);
        chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
        chk({tag, "_urun"}, {24'd0, underrun_cnt}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; ram_valid = 1'b0; ram_data = 16'h0000; sample_tick = 1'b0;
        s_enable = 1'b0; s_ram_valid = 1'b0; s_ram_data = 16'h0000; s_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");

        // Prime and release
        rst_n = 1'b1;
        enable = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("rdy_prime", {31'd0, audio_rdy}, 32'd1);
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 16'h0000);
        chk("level_primed", {27'd0, level}, 32'd8);
        step(1'b0, 16'h0000, 1'b1, 16'h0000);      // still PRIME at this edge: silence
        chk("level_after_silence", {27'd0, level}, 32'd8);
        step(1'b0, 16'h0000, 1'b1, 16'h0001);
        chk("valid_pulse_hi", {31'd0, sample_valid}, 32'd1);
        chk("level_after_pop", {27'd0, level}, 32'd7);
        step(1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("valid_pulse_lo", {31'd0, sample_valid}, 32'd0);

        // Underrun
        for (int i = 2; i <= 8; i++) step(1'b0, 16'h0000, 1'b1, 16'(i));
        chk("level_drained", {27'd0, level}, 32'd0);
        chk("urun_before", {24'd0, underrun_cnt}, 32'd0);
        step(1'b0, 16'h0000, 1'b1, 16'h0008);      // underrun holds last word
        chk("urun_one", {24'd0, underrun_cnt}, 32'd1);
        step(1'b0, 16'h0000, 1'b1, 16'h0000);      // back in PRIME: silence
        chk("urun_still_one", {24'd0, underrun_cnt}, 32'd1);

        // Simultaneous push and tick
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0010 + i), 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 16'(16'h0010 + i));
        chk("level_five", {27'd0, level}, 32'd5);
        step(1'b1, 16'h0099, 1'b1, 16'h0013);
        chk("level_simul", {27'd0, level}, 32'd5);
        for (int i = 4; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 16'(16'h0010 + i));
        step(1'b0, 16'h0000, 1'b1, 16'h0099);
        chk("level_empty", {27'd0, level}, 32'd0);

        // Flow control and overflow
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 16'(16'h0100 + k), 1'b0, 16'h0000);
            if (k == 13) chk("rdy_at_13", {31'd0, audio_rdy}, 32'd1);
            if (k == 14) chk("rdy_at_14", {31'd0, audio_rdy}, 32'd0);
        end
        chk("level_full", {27'd0, level}, 32'd16);
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        step(1'b1, 16'h0111, 1'b0, 16'h0000);
        chk("ovf_after", {31'd0, overflow}, 32'd1);
        chk("level_stays_full", {27'd0, level}, 32'd16);

        // Drain to 10, then disable
        for (int i = 1; i <= 6; i++) step(1'b0, 16'h0000, 1'b1, 16'(16'h0100 + i));
        chk("level_ten", {27'd0, level}, 32'd10);
        chk("rdy_at_ten", {31'd0, audio_rdy}, 32'd1);
        enable = 1'b0;
        step(1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("dis_level", {27'd0, level}, 32'd0);
        chk("dis_rdy", {31'd0, audio_rdy}, 32'd0);
        chk("dis_sample", {16'd0, sample_out}, 32'h0106);
        chk("dis_ovf", {31'd0, overflow}, 32'd1);
        chk("dis_urun", {24'd0, underrun_cnt}, 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");

        // Saturation on the PRIME_LEVEL=1 instance
        @(negedge clk);
        rst_n = 1'b1;
        s_enable = 1'b1;
        sstep(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            sstep(1'b1, 16'(i), 1'b0);
            sstep(1'b0, 16'h0000, 1'b0);
            sstep(1'b0, 16'h0000, 1'b1);
            sstep(1'b0, 16'h0000, 1'b1);
            if (i == 99) chk("sat_mid", {24'd0, s_urun}, 32'd100);
        end
        chk("sat_hold", {24'd0, s_urun}, 32'd255);
        chk("sat_level", {27'd0, s_level}, 32'd0);

        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
